// File: rtl/keyboard_frame_receiver.sv
// rtl/keyboard_frame_receiver.sv - PS/2 11-bit frame receiver with parity/stop checks and watchdog
module keyboard_frame_receiver #(
    parameter int TIMEOUT_BIT_SIZE = 16,
    parameter int TIMEOUT_CYCLES   = 50000
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_edge_en,
    input  logic       i_ps2_dat,
    output logic [7:0] o_dat,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [TIMEOUT_BIT_SIZE-1:0] WD_LAST = TIMEOUT_BIT_SIZE'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_BIT_SIZE-1:0] WD_ONE  = TIMEOUT_BIT_SIZE'(1);

    state_t                      state;
    logic [1:0]                  sync;
    logic [3:0]                  count;
    logic [7:0]                  shift;
    logic                        parity;
    logic [TIMEOUT_BIT_SIZE-1:0] wdog;
    logic                        bit_in;

    assign bit_in = sync[1];

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            sync         <= 2'b00;
            state        <= IDLE;
            count        <= 4'd0;
            shift        <= 8'h00;
            parity       <= 1'b0;
            wdog         <= '0;
            o_dat        <= 8'h00;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            sync         <= {sync[0], i_ps2_dat};
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;

            if (i_edge_en) begin
                // An edge always wins over a watchdog expiry in the same cycle
                wdog <= '0;
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state  <= DATA;
                            count  <= 4'd0;
                            o_busy <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift <= {bit_in, shift[7:1]};
                        count <= count + 4'd1;
                        if (count == 4'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity <= bit_in;
                        state  <= STOP;
                    end
                    STOP: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        if (bit_in) begin
                            o_dat <= shift;
                            if (^{shift, parity}) begin
                                o_valid <= 1'b1;
                            end else begin
                                o_parity_err <= 1'b1;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end else if (state == IDLE) begin
                wdog <= '0;
            end else if (wdog == WD_LAST) begin
                wdog        <= '0;
                state       <= IDLE;
                o_busy      <= 1'b0;
                o_frame_err <= 1'b1;
            end else begin
                wdog <= wdog + WD_ONE;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_frame_receiver.sv
// tb/tb_keyboard_frame_receiver.sv - scoreboard bench for keyboard_frame_receiver
module tb_keyboard_frame_receiver;

    localparam int K_VALID = 1;
    localparam int K_PERR  = 2;
    localparam int K_FERR  = 3;

    logic       clk = 1'b0;
    logic       i_sclr = 1'b1;
    logic       i_edge_en = 1'b0;
    logic       i_ps2_dat = 1'b1;
    logic [7:0] o_dat;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    typedef struct {
        int         kind;
        logic [7:0] dat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    keyboard_frame_receiver #(
        .TIMEOUT_BIT_SIZE(16),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_edge_en   (i_edge_en),
        .i_ps2_dat   (i_ps2_dat),
        .o_dat       (o_dat),
        .o_valid     (o_valid),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        i_ps2_dat = b;
        repeat (4) @(negedge clk);
        i_edge_en = 1'b1;
        @(negedge clk);
        i_edge_en = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        i_ps2_dat = 1'b1;
    endtask

    task automatic expect_out(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.dat  = d;
        q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    initial begin
        exp_t e;
        int   act_kind;
        forever begin
            @(negedge clk);
            if (o_valid || o_parity_err || o_frame_err) begin
                check("pulse_onehot", $countones({o_valid, o_parity_err, o_frame_err}), 1);
                act_kind = o_valid ? K_VALID : (o_parity_err ? K_PERR : K_FERR);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got kind %0d dat %0h, expected no pulse",
                             act_kind, o_dat);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", act_kind, e.kind);
                    check("pulse_dat", int'(o_dat), int'(e.dat));
                    check("busy_at_pulse", int'(o_busy), 0);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dat", int'(o_dat), 8'h00);
        check("rst_busy", int'(o_busy), 0);
        check("rst_pulses", int'({o_valid, o_parity_err, o_frame_err}), 0);
        i_sclr = 1'b0;
        repeat (5) @(negedge clk);

        // 1: good 0x1C
        expect_out(K_VALID, 8'h1C);
        send_bit(1'b0);
        check("busy_mid_frame", int'(o_busy), 1);
        for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("idle_after_frame", int'(o_busy), 0);

        // 2: back-to-back 0xF0 and 0x1C
        expect_out(K_VALID, 8'hF0);
        send_frame(8'hF0, 1'b1, 1'b1);
        expect_out(K_VALID, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);

        // 3: bad parity
        expect_out(K_PERR, 8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1);

        // 4: bad stop bit; o_dat keeps 0x1C
        expect_out(K_FERR, 8'h1C);
        send_frame(8'h5A, 1'b1, 1'b0);
        i_ps2_dat = 1'b1;

        // 5: stalled frame aborted by watchdog, then a good frame
        expect_out(K_FERR, 8'h1C);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (80) @(negedge clk);
        check("busy_after_timeout", int'(o_busy), 0);
        check("queue_after_timeout", q.size(), 0);
        expect_out(K_VALID, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);

        // 6: reset mid-frame, idle-high edges, then a good frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        i_sclr = 1'b1;
        @(negedge clk);
        i_sclr = 1'b0;
        check("sclr_dat", int'(o_dat), 8'h00);
        check("sclr_busy", int'(o_busy), 0);
        check("sclr_pulses", int'({o_valid, o_parity_err, o_frame_err}), 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("idle_edges_busy", int'(o_busy), 0);
        expect_out(K_VALID, 8'h29);
        send_frame(8'h29, 1'b0, 1'b1);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("final_dat", int'(o_dat), 8'h29);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
